// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter/sequencer for a 1 KiB byte-
//               addressed data memory. Port 0 = fetch, port 1 = load/store.
//               Serialises word accesses into single-cycle memory strobes and
//               returns read data per port with a one-cycle ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int ALIGN_CHECK = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    input  logic [DATA_W-1:0] mem_rddata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                r_gnt;
    logic                r_we;
    logic                w_grant;
    logic                w_gnt_port;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_misalign;

    // Grant decision and command selection; only meaningful while IDLE
    always_comb begin
        w_gnt_port = req1;
        if (req0 && req1) begin
            w_gnt_port = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        end
        w_grant     = (r_state == IDLE) && (req0 || req1);
        w_sel_we    = w_gnt_port ? we1    : we0;
        w_sel_addr  = w_gnt_port ? addr1  : addr0;
        w_sel_wdata = w_gnt_port ? wdata1 : wdata0;
        w_misalign  = (ALIGN_CHECK != 0) && (w_sel_addr[1:0] != 2'b00);
    end

    // Next-state logic: misaligned grants skip the memory access entirely
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_grant ? (w_misalign ? RESP : ACCESS) : IDLE;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs: memory strobes, acks, per-port read data, grant history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            busy         <= 1'b0;
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            mem_wrdata   <= '0;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            mem_wrdata <= '0;
            busy       <= (w_next != IDLE);

            if (w_grant) begin
                r_gnt        <= w_gnt_port;
                r_we         <= w_sel_we;
                r_last_grant <= w_gnt_port;
                if (w_misalign) begin
                    // Error response goes out next cycle and clears read data
                    if (w_gnt_port) begin
                        ack1   <= 1'b1;
                        err1   <= 1'b1;
                        rdata1 <= '0;
                    end else begin
                        ack0   <= 1'b1;
                        err0   <= 1'b1;
                        rdata0 <= '0;
                    end
                end else begin
                    // The strobe registers themselves hold the latched command
                    mem_addr   <= w_sel_addr;
                    mem_write  <= w_sel_we;
                    mem_read   <= ~w_sel_we;
                    mem_wrdata <= w_sel_we ? w_sel_wdata : '0;
                end
            end

            if (r_state == ACCESS) begin
                if (r_gnt) begin
                    ack1 <= 1'b1;
                    if (!r_we) begin
                        rdata1 <= mem_rddata;
                    end
                end else begin
                    ack0 <= 1'b1;
                    if (!r_we) begin
                        rdata0 <= mem_rddata;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a byte-wide
//               memory model behind the mem_* interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        busy, mem_write, mem_read;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wrdata, mem_rddata;

    mem_arbiter #(
        .ADDR_W(10), .DATA_W(32), .ALIGN_CHECK(1), .FIXED_PRIO(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory model: little-endian word, combinational read, commit on edge
    logic [7:0] mem [0:1023];
    logic [9:0] a1, a2, a3;
    always_comb begin
        a1 = mem_addr + 10'd1;
        a2 = mem_addr + 10'd2;
        a3 = mem_addr + 10'd3;
        mem_rddata = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
    end
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wrdata[7:0];
            mem[a1]       <= mem_wrdata[15:8];
            mem[a2]       <= mem_wrdata[23:16];
            mem[a3]       <= mem_wrdata[31:24];
        end
    end

    // Strobe monitor
    int          wr_cnt = 0, rd_cnt = 0, overlap_cnt = 0;
    logic [9:0]  last_waddr;
    logic [31:0] last_wdata;
    always @(negedge clk) begin
        if (mem_write && mem_read) overlap_cnt++;
        if (mem_write) begin
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wrdata;
        end
        if (mem_read) rd_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE: returns cycles to ack, response data and err;
    // leaves the bench in the following IDLE cycle.
    task automatic xfer(input string tag, input int p, input logic we, input logic [9:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er);
        logic got;
        got = 1'b0;
        lat = 0;
        if (p == 0) begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        else        begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        for (int k = 0; k < 20; k++) begin
            tick();
            lat++;
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_ack"}, {31'd0, got}, 32'd1);
        rd = (p == 0) ? rdata0 : rdata1;
        er = (p == 0) ? err0 : err1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    int          lat, w0, r0, nacks, busy_low, first;
    logic [31:0] rd;
    logic        er, ab_ack;
    int          order [8];
    int          t_ack [8];
    int          cyc;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {25'd0, ack0, ack1, err0, err1, busy, mem_write, mem_read}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_maddr", {22'd0, mem_addr}, 32'd0);
        check("rst_mwdata", mem_wrdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Write then read back from the other port
        w0 = wr_cnt;
        xfer("wr0", 0, 1'b1, 10'h010, 32'hDEADBEEF, lat, rd, er);
        check("wr0_lat", lat, 32'd2);
        check("wr0_err", {31'd0, er}, 32'd0);
        check("wr0_strobes", wr_cnt - w0, 32'd1);
        check("wr0_addr", {22'd0, last_waddr}, 32'h010);
        check("wr0_data", last_wdata, 32'hDEADBEEF);
        check("wr0_rdata_kept", rdata0, 32'd0);
        xfer("rd1", 1, 1'b0, 10'h010, 32'd0, lat, rd, er);
        check("rd1_lat", lat, 32'd2);
        check("rd1_data", rd, 32'hDEADBEEF);
        check("rd1_err", {31'd0, er}, 32'd0);

        // Misaligned write on port 1
        w0 = wr_cnt; r0 = rd_cnt;
        xfer("mis1", 1, 1'b1, 10'h013, 32'hCAFEF00D, lat, rd, er);
        check("mis1_lat", lat, 32'd1);
        check("mis1_err", {31'd0, er}, 32'd1);
        check("mis1_rdata", rd, 32'd0);
        check("mis1_nostrobe", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);

        // Contention: both ports held, last grant was port 1 so port 0 leads
        for (int i = 0; i < 8; i++) begin order[i] = -1; t_ack[i] = 0; end
        we0 = 0; addr0 = 10'h000; we1 = 0; addr1 = 10'h004;
        req0 = 1; req1 = 1;
        nacks = 0;
        for (int c = 1; c <= 60 && nacks < 8; c++) begin
            tick();
            if (ack0) begin order[nacks] = 0; t_ack[nacks] = c; nacks++; end
            else if (ack1) begin order[nacks] = 1; t_ack[nacks] = c; nacks++; end
        end
        req0 = 0; req1 = 0;
        tick();
        check("cont_count", nacks, 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("cont_order%0d", i), order[i], i % 2);
        for (int i = 1; i < 8; i++) check($sformatf("cont_gap%0d", i), t_ack[i] - t_ack[i-1], 32'd3);
        check("cont_rdata0", rdata0, 32'hA6A7A4A5);
        check("cont_rdata1", rdata1, 32'hA2A3A0A1);

        // Throughput: port 0 alone, held
        we0 = 0; addr0 = 10'h008; req0 = 1;
        nacks = 0; busy_low = 0;
        for (int c = 1; c <= 40 && nacks < 4; c++) begin
            tick();
            if (nacks > 0 && !busy) busy_low++;
            if (ack0) begin t_ack[nacks] = c; nacks++; end
        end
        req0 = 0;
        tick();
        check("thr_count", nacks, 32'd4);
        for (int i = 1; i < 4; i++) check($sformatf("thr_gap%0d", i), t_ack[i] - t_ack[i-1], 32'd3);
        check("thr_busy_low", busy_low, 32'd3);

        // Abort: reset during ACCESS of a port-0 write
        we0 = 1; addr0 = 10'h020; wdata0 = 32'h12345678; req0 = 1;
        tick();
        check("abort_in_access", {31'd0, mem_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctl", {25'd0, ack0, ack1, err0, err1, busy, mem_write, mem_read}, 32'd0);
        check("abort_maddr", {22'd0, mem_addr}, 32'd0);
        req0 = 0; we0 = 0;
        tick();
        rst_n = 1'b1;
        check("abort_rdata0", rdata0, 32'd0);
        check("abort_rdata1", rdata1, 32'd0);
        ab_ack = 1'b0;
        repeat (3) begin
            tick();
            ab_ack = ab_ack | ack0 | ack1;
        end
        check("abort_noack", {31'd0, ab_ack}, 32'd0);
        addr0 = 10'h020; addr1 = 10'h024; we0 = 0; we1 = 0;
        req0 = 1; req1 = 1;
        first = -1;
        for (int c = 0; c < 20 && first < 0; c++) begin
            tick();
            if (ack0) first = 0;
            else if (ack1) first = 1;
        end
        req0 = 0;
        check("abort_first", first, 32'd0);
        check("abort_old_data", rdata0, 32'h86878485);
        cyc = 0;
        while (!ack1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("abort_port1_ack", {31'd0, ack1}, 32'd1);
        req1 = 0;
        repeat (2) tick();

        check("no_rw_overlap", overlap_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
